gate_equiv_sequencer: RTL and testbench

//  Clocked stimulus generator and equivalence checker for a pair of gate implementations.

---
 rtl/gate_equiv_sequencer.sv | 123 ++++++++++++
 tb/tb_gate_equiv_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/gate_equiv_sequencer.sv
// Sweeps every input vector into two gate implementations,
// compares their outputs after a settle window and reports pass/fail.
module gate_equiv_sequencer #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             a,
  input  logic             b,
  output logic [N_IN-1:0]  x,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [N_IN-1:0]  fail_vec
);

  localparam int WC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [N_IN-1:0]  x_q;
  logic [N_IN-1:0]  fvec_q;
  logic [WC_W-1:0]  wcnt_q;
  logic [CNT_W-1:0] err_q;
  logic [CNT_W-1:0] err_d;
  logic             first_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             fv_q;
  logic             mism;

  // Mismatch detect and saturating error count candidate
  always_comb begin
    mism  = a ^ b;
    err_d = err_q;
    if (mism && (err_q != '1)) begin
      err_d = err_q + CNT_W'(1);
    end
  end

  // Sweep FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      fvec_q  <= '0;
      wcnt_q  <= '0;
      err_q   <= '0;
      first_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fv_q    <= 1'b0;
    end else begin
      fv_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_WAIT;
            x_q     <= '0;
            wcnt_q  <= '0;
            err_q   <= '0;
            fvec_q  <= '0;
            first_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        S_WAIT: begin
          if (wcnt_q == WC_LAST) begin
            state_q <= S_CHECK;
          end else begin
            wcnt_q <= wcnt_q + WC_W'(1);
          end
        end
        S_CHECK: begin
          if (mism) begin
            fv_q  <= 1'b1;
            err_q <= err_d;
            if (!first_q) begin
              fvec_q  <= x_q;
              first_q <= 1'b1;
            end
          end
          if (x_q == '1) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            state_q <= S_WAIT;
            x_q     <= x_q + N_IN'(1);
            wcnt_q  <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign x          = x_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign fail_valid = fv_q;
  assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_gate_equiv_sequencer.sv
// Directed bench: default instance plus a 1-bit-counter instance
// sharing clock, reset and start.
module tb_gate_equiv_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       or_mode = 1'b0;

  logic       a_m, b_m;
  logic [1:0] x;
  logic       busy, done, pass, fail_valid;
  logic [7:0] err_cnt;
  logic [1:0] fail_vec;

  logic       a_s, b_s;
  logic [1:0] x_s;
  logic       busy_s, done_s, pass_s, fv_s;
  logic [0:0] err_s;
  logic [1:0] fvec_s;

  int n_chk = 0;
  int n_err = 0;
  int pv, ps;

  always #5 clk = ~clk;

  assign a_m = &x;
  assign b_m = or_mode ? |x : &x;
  assign a_s = &x_s;
  assign b_s = ~a_s;

  gate_equiv_sequencer #(.N_IN(2), .SETTLE(1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a_m), .b(b_m), .x(x), .busy(busy),
    .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_valid(fail_valid), .fail_vec(fail_vec)
  );

  gate_equiv_sequencer #(.N_IN(2), .SETTLE(1), .CNT_W(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a_s), .b(b_s), .x(x_s), .busy(busy_s),
    .done(done_s), .pass(pass_s), .err_cnt(err_s),
    .fail_valid(fv_s), .fail_vec(fvec_s)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_x"}, x, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err"}, err_cnt, 0);
    chk({tag, "_fv"}, fail_valid, 0);
    chk({tag, "_fvec"}, fail_vec, 0);
    chk({tag, "_s_err"}, err_s, 0);
    chk({tag, "_s_x"}, x_s, 0);
  endtask

  // Start pulse at edge k, then edges k+1..k+8; x=j after edge k+2j
  task automatic sweep(input bit mid, output int nv, output int ns);
    nv = 0;
    ns = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("sw_busy", busy, 1);
    chk("sw_x0", x, 0);
    chk("sw_err0", err_cnt, 0);
    for (int e = 1; e <= 8; e++) begin
      start = (mid && (e == 2 || e == 3)) ? 1'b1 : 1'b0;
      tick();
      nv += int'(fail_valid);
      ns += int'(fv_s);
      if (e == 2 || e == 4 || e == 6) chk("sw_xstep", x, e / 2);
      if (e == 7) chk("sw_done_early", done, 0);
    end
    start = 1'b0;
    chk("sw_done", done, 1);
    chk("sw_busy_end", busy, 0);
    chk("sw_x_hold", x, 3);
  endtask

  initial begin
    // 1: reset and idle
    #2 rst_n = 1'b0;
    #1 chk_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk_zero("idle");

    // 2: equivalent pair; 4: saturation on the second instance
    or_mode = 1'b0;
    sweep(1'b0, pv, ps);
    chk("eq_pass", pass, 1);
    chk("eq_err", err_cnt, 0);
    chk("eq_pulses", pv, 0);
    chk("sat_pulses", ps, 4);
    chk("sat_err", err_s, 1);
    chk("sat_fvec", fvec_s, 0);
    chk("sat_pass", pass_s, 0);
    chk("sat_done", done_s, 1);
    tick();
    chk("eq_x_hold2", x, 3);
    chk("eq_done_hold", done, 1);

    // 3: faulty B = OR
    or_mode = 1'b1;
    sweep(1'b0, pv, ps);
    chk("or_pulses", pv, 2);
    chk("or_err", err_cnt, 2);
    chk("or_fvec", fail_vec, 1);
    chk("or_pass", pass, 0);

    // 5: reset mid-sweep at x=2
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("mid_x2", x, 2);
    chk("mid_err1", err_cnt, 1);
    chk("mid_fvec1", fail_vec, 1);
    rst_n = 1'b0;
    #1 chk_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    or_mode = 1'b0;
    sweep(1'b0, pv, ps);
    chk("post_pass", pass, 1);
    chk("post_pulses", pv, 0);

    // 6: start during WAIT/CHECK ignored; held in DONE restarts
    or_mode = 1'b1;
    sweep(1'b1, pv, ps);
    chk("ign_pulses", pv, 2);
    chk("ign_err", err_cnt, 2);
    chk("ign_fvec", fail_vec, 1);
    start = 1'b1;
    tick();
    chk("rs_busy", busy, 1);
    chk("rs_done", done, 0);
    chk("rs_err", err_cnt, 0);
    chk("rs_fvec", fail_vec, 0);
    chk("rs_x", x, 0);
    chk("rs_pass", pass, 0);
    tick();
    tick();
    chk("rs_hold_busy", busy, 1);
    chk("rs_hold_x", x, 1);
    start = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
